// File: rtl/dsadc_sched_pkg.sv
// Shared types and widths for the delta-sigma ADC conversion scheduler.
package dsadc_sched_pkg;
  localparam int ADC_W    = 16;
  localparam int DIV_W    = 5;
  localparam int SETTLE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEL    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CONV   = 3'd3,
    ST_STORE  = 3'd4,
    ST_NEXT   = 3'd5
  } state_t;
endpackage

// File: rtl/dsadc_chpick.sv
// Priority finder: lowest set mask bit, either anywhere or strictly above cur.
module dsadc_chpick #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic [NCH-1:0] mask,
  input  logic [CHW-1:0] cur,
  input  logic           from_bottom,
  output logic [CHW-1:0] next_ch,
  output logic           found
);
  // Scan downward so the lowest qualifying bit is the last one written.
  always_comb begin
    next_ch = '0;
    found   = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (from_bottom || (i > int'(cur)))) begin
        next_ch = CHW'(i);
        found   = 1'b1;
      end else begin
        next_ch = next_ch;
        found   = found;
      end
    end
  end
endmodule

// File: rtl/dsadc_sched.sv
// Time-shares one delta-sigma ADC core across NCH muxed inputs and keeps
// a per-channel result register file with fresh flags.
module dsadc_sched
  import dsadc_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                continuous,
  input  logic [NCH-1:0]      ch_mask,
  input  logic [DIV_W-1:0]    divider_cfg,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic                adc_rst,
  output logic [DIV_W-1:0]    adc_divider,
  output logic [CHW-1:0]      adc_sel,
  input  logic [ADC_W-1:0]    adc_val,
  input  logic                adc_valid,
  input  logic [CHW-1:0]      rd_ch,
  input  logic                rd_strobe,
  output logic [ADC_W-1:0]    rd_val,
  output logic [NCH-1:0]      fresh,
  output logic                busy,
  output logic                done
);
  state_t              state_r;
  logic [CHW-1:0]      ch_r;
  logic [NCH-1:0]      mask_r;
  logic [DIV_W-1:0]    div_r;
  logic [SETTLE_W-1:0] settle_r;
  logic [SETTLE_W-1:0] cnt_r;
  logic [ADC_W-1:0]    result_r [NCH];

  logic [CHW-1:0]      first_ch_s;
  logic [CHW-1:0]      next_ch_s;
  logic                first_found_s;
  logic                next_found_s;
  logic                capture_s;
  logic [NCH-1:0]      set_s;
  logic [NCH-1:0]      clr_s;

  // First channel comes straight from the live inputs so a continuous reload
  // in NEXT can pick it in the same cycle as the end-of-sweep search.
  dsadc_chpick #(.NCH(NCH), .CHW(CHW)) u_pick_first (
    .mask        (ch_mask),
    .cur         ('0),
    .from_bottom (1'b1),
    .next_ch     (first_ch_s),
    .found       (first_found_s)
  );

  dsadc_chpick #(.NCH(NCH), .CHW(CHW)) u_pick_next (
    .mask        (mask_r),
    .cur         (ch_r),
    .from_bottom (1'b0),
    .next_ch     (next_ch_s),
    .found       (next_found_s)
  );

  assign capture_s = (state_r == ST_CONV) && adc_valid;
  assign set_s     = capture_s ? ({{(NCH-1){1'b0}}, 1'b1} << ch_r) : '0;
  assign clr_s     = rd_strobe ? ({{(NCH-1){1'b0}}, 1'b1} << rd_ch) : '0;

  // Sequencer: mux select, settle, convert, capture, advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ch_r        <= '0;
      mask_r      <= '0;
      div_r       <= '0;
      settle_r    <= '0;
      cnt_r       <= '0;
      adc_rst     <= 1'b1;
      adc_divider <= '0;
      adc_sel     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          adc_rst <= 1'b1;
          if ((start || continuous) && first_found_s) begin
            mask_r   <= ch_mask;
            div_r    <= divider_cfg;
            settle_r <= settle_cycles;
            ch_r     <= first_ch_s;
            busy     <= 1'b1;
            state_r  <= ST_SEL;
          end
        end
        ST_SEL: begin
          adc_sel     <= ch_r;
          adc_divider <= div_r;
          cnt_r       <= settle_r;
          state_r     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_r == '0) begin
            adc_rst <= 1'b0;
            state_r <= ST_CONV;
          end else begin
            cnt_r <= cnt_r - SETTLE_W'(1);
          end
        end
        ST_CONV: begin
          if (adc_valid) begin
            adc_rst <= 1'b1;
            state_r <= ST_STORE;
          end
        end
        // One idle cycle lets the core's sticky valid fall after adc_rst.
        ST_STORE: state_r <= ST_NEXT;
        ST_NEXT: begin
          if (next_found_s) begin
            ch_r    <= next_ch_s;
            state_r <= ST_SEL;
          end else begin
            done <= 1'b1;
            if (continuous && first_found_s) begin
              mask_r   <= ch_mask;
              div_r    <= divider_cfg;
              settle_r <= settle_cycles;
              ch_r     <= first_ch_s;
              state_r  <= ST_SEL;
            end else begin
              busy    <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          adc_rst <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Result register file; written once per conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) result_r[i] <= '0;
    end else if (capture_s) begin
      result_r[ch_r] <= adc_val;
    end
  end

  // Fresh flags: a capture outranks a same-cycle read acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fresh <= '0;
    end else begin
      fresh <= (fresh & ~clr_s) | set_s;
    end
  end

  // Read port.
  always_comb begin
    if (int'(rd_ch) < NCH) begin
      rd_val = result_r[rd_ch];
    end else begin
      rd_val = '0;
    end
  end
endmodule

// File: tb/tb_dsadc_sched.sv
// Directed bench for dsadc_sched with a behavioural ADC core stub.
module tb_dsadc_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        continuous;
  logic [3:0]  ch_mask;
  logic [4:0]  divider_cfg;
  logic [7:0]  settle_cycles;
  logic        adc_rst;
  logic [4:0]  adc_divider;
  logic [1:0]  adc_sel;
  logic [15:0] adc_val;
  logic        adc_valid;
  logic [1:0]  rd_ch;
  logic        rd_strobe;
  logic [15:0] rd_val;
  logic [3:0]  fresh;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  // Stub state
  logic [1:0]  stub_cnt;
  logic        prev_rst;
  logic [15:0] conv_count;
  logic        mode_inc;

  int         n_done;
  logic [1:0] order_q[$];

  always #5 clk = ~clk;

  dsadc_sched #(.NCH(4), .CHW(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .divider_cfg(divider_cfg), .settle_cycles(settle_cycles),
    .adc_rst(adc_rst), .adc_divider(adc_divider), .adc_sel(adc_sel),
    .adc_val(adc_val), .adc_valid(adc_valid), .rd_ch(rd_ch), .rd_strobe(rd_strobe),
    .rd_val(rd_val), .fresh(fresh), .busy(busy), .done(done)
  );

  // ADC stub: valid rises three clocks after adc_rst falls, sticky until adc_rst.
  always @(posedge clk) begin
    prev_rst <= adc_rst;
    if (adc_rst === 1'b1 && prev_rst === 1'b0) conv_count <= conv_count + 16'd1;
    if (adc_rst !== 1'b0) begin
      stub_cnt  <= 2'd0;
      adc_valid <= 1'b0;
    end else begin
      if (stub_cnt == 2'd2) adc_valid <= 1'b1;
      if (stub_cnt != 2'd3) stub_cnt <= stub_cnt + 2'd1;
    end
  end

  assign adc_val = mode_inc ? (16'h0200 + conv_count) : (16'h0100 + {14'd0, adc_sel});

  task automatic run_until_done(input int maxc, output bit ok);
    ok = 1'b0;
    n_done = 0;
    order_q.delete();
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (adc_valid && !adc_rst) order_q.push_back(adc_sel);
      if (done) begin
        n_done++;
        ok = 1'b1;
      end
    end
  endtask

  task automatic clear_fresh();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rd_ch = 2'(c);
      rd_strobe = 1'b1;
    end
    @(negedge clk);
    rd_strobe = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] m, input logic [7:0] s, input logic [4:0] d);
    @(negedge clk);
    ch_mask = m;
    settle_cycles = s;
    divider_cfg = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (adc_rst !== 1'b1) begin fails++; $display("FAIL reset_adc_rst got %b want 1", adc_rst); end
    tests++; if (adc_divider !== 5'd0) begin fails++; $display("FAIL reset_divider got %0d want 0", adc_divider); end
    tests++; if (adc_sel !== 2'd0) begin fails++; $display("FAIL reset_sel got %0d want 0", adc_sel); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    tests++; if (fresh !== 4'b0000) begin fails++; $display("FAIL reset_fresh got %b want 0000", fresh); end
    for (int c = 0; c < 4; c++) begin
      rd_ch = 2'(c);
      #1;
      tests++; if (rd_val !== 16'h0000) begin fails++; $display("FAIL reset_result%0d got %h want 0000", c, rd_val); end
    end
  endtask

  task automatic test_sweep();
    bit ok;
    int extra;
    logic [15:0] exp_v [4];
    exp_v[0] = 16'h0100; exp_v[1] = 16'h0101; exp_v[2] = 16'h0000; exp_v[3] = 16'h0103;
    mode_inc = 1'b0;
    pulse_start(4'b1011, 8'd3, 5'd4);
    run_until_done(300, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL sweep_timeout got no done want done"); end
    tests++; if (order_q.size() != 3) begin fails++; $display("FAIL sweep_order_len got %0d want 3", order_q.size()); end
    else begin
      tests++; if (order_q[0] !== 2'd0 || order_q[1] !== 2'd1 || order_q[2] !== 2'd3) begin
        fails++; $display("FAIL sweep_order got %0d,%0d,%0d want 0,1,3", order_q[0], order_q[1], order_q[2]);
      end
    end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL sweep_idle got busy=%b want 0", busy); end
    extra = 0;
    repeat (8) begin @(negedge clk); if (done) extra++; end
    tests++; if (extra != 0) begin fails++; $display("FAIL sweep_extra_done got %0d want 0", extra); end
    tests++; if (fresh !== 4'b1011) begin fails++; $display("FAIL sweep_fresh got %b want 1011", fresh); end
    for (int c = 0; c < 4; c++) begin
      rd_ch = 2'(c);
      #1;
      tests++; if (rd_val !== exp_v[c]) begin fails++; $display("FAIL sweep_result%0d got %h want %h", c, rd_val, exp_v[c]); end
    end
  endtask

  task automatic test_timing();
    int waited;
    clear_fresh();
    @(negedge clk);                       // cycle T
    ch_mask = 4'b0100; settle_cycles = 8'd0; divider_cfg = 5'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;         // T+1
    @(negedge clk);                       // T+2
    tests++; if (adc_sel !== 2'd2 || busy !== 1'b1) begin fails++; $display("FAIL timing_sel got sel=%0d busy=%b want 2 1", adc_sel, busy); end
    tests++; if (adc_divider !== 5'd7 || adc_rst !== 1'b1) begin fails++; $display("FAIL timing_div got div=%0d rst=%b want 7 1", adc_divider, adc_rst); end
    @(negedge clk);                       // T+3
    tests++; if (adc_rst !== 1'b0) begin fails++; $display("FAIL timing_rst_fall got %b want 0", adc_rst); end
    waited = 0;
    while (!adc_valid && waited < 20) begin @(negedge clk); waited++; end
    tests++; if (waited != 3) begin fails++; $display("FAIL timing_valid_wait got %0d want 3", waited); end
    @(negedge clk);                       // V+1
    rd_ch = 2'd2;
    #1;
    tests++; if (adc_rst !== 1'b1) begin fails++; $display("FAIL timing_rst_rise got %b want 1", adc_rst); end
    tests++; if (fresh !== 4'b0100 || rd_val !== 16'h0102) begin fails++; $display("FAIL timing_capture got fresh=%b val=%h want 0100 0102", fresh, rd_val); end
    @(negedge clk);                       // V+2
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL timing_done_early got %b want 0", done); end
    @(negedge clk);                       // V+3
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL timing_done got %b want 1", done); end
    @(negedge clk);                       // V+4
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL timing_end got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_collision();
    bit ok;
    int waited;
    logic [15:0] base;
    clear_fresh();
    mode_inc = 1'b1;
    base = conv_count;
    pulse_start(4'b0010, 8'd0, 5'd1);
    waited = 0;
    while (!adc_valid && waited < 30) begin @(negedge clk); waited++; end
    tests++; if (adc_valid !== 1'b1) begin fails++; $display("FAIL collide_timeout got no valid want valid"); end
    rd_ch = 2'd1; rd_strobe = 1'b1;
    #1;
    tests++; if (rd_val !== 16'h0101) begin fails++; $display("FAIL collide_old_val got %h want 0101", rd_val); end
    @(negedge clk);
    rd_strobe = 1'b0;
    #1;
    tests++; if (fresh[1] !== 1'b1) begin fails++; $display("FAIL collide_fresh got %b want 1", fresh[1]); end
    tests++; if (rd_val !== 16'h0200 + base) begin fails++; $display("FAIL collide_new_val got %h want %h", rd_val, 16'h0200 + base); end
    run_until_done(50, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL collide_done got no done want done"); end
    @(negedge clk); rd_ch = 2'd1; rd_strobe = 1'b1;
    @(negedge clk); rd_strobe = 1'b0;
    tests++; if (fresh[1] !== 1'b0) begin fails++; $display("FAIL strobe_clear got %b want 0", fresh[1]); end
    mode_inc = 1'b0;
  endtask

  task automatic test_mask_zero();
    logic seen_busy, seen_done;
    seen_busy = 1'b0; seen_done = 1'b0;
    pulse_start(4'b0000, 8'd0, 5'd2);
    repeat (10) begin
      @(negedge clk);
      seen_busy |= busy;
      seen_done |= done;
    end
    tests++; if (seen_busy !== 1'b0 || seen_done !== 1'b0) begin fails++; $display("FAIL mask_zero got busy=%b done=%b want 0 0", seen_busy, seen_done); end
  endtask

  task automatic test_start_busy();
    bit ok;
    int extra;
    clear_fresh();
    pulse_start(4'b0011, 8'd0, 5'd3);
    @(negedge clk);
    ch_mask = 4'b1100; start = 1'b1;
    @(negedge clk); start = 1'b0;
    run_until_done(100, ok);
    tests++; if (ok !== 1'b1 || order_q.size() != 2) begin fails++; $display("FAIL busy_start_len got ok=%b n=%0d want 1 2", ok, order_q.size()); end
    else begin
      tests++; if (order_q[0] !== 2'd0 || order_q[1] !== 2'd1) begin fails++; $display("FAIL busy_start_order got %0d,%0d want 0,1", order_q[0], order_q[1]); end
    end
    extra = 0;
    repeat (10) begin @(negedge clk); if (done || busy) extra++; end
    tests++; if (extra != 0 || fresh !== 4'b0011) begin fails++; $display("FAIL busy_start_after got extra=%0d fresh=%b want 0 0011", extra, fresh); end
  endtask

  task automatic test_continuous();
    int nconv, ndone, waited, late_done;
    logic dropped_busy;
    logic [15:0] base;
    clear_fresh();
    mode_inc = 1'b1;
    base = conv_count;
    @(negedge clk);
    ch_mask = 4'b0001; settle_cycles = 8'd1; divider_cfg = 5'd5; continuous = 1'b1;
    nconv = 0; ndone = 0; waited = 0; dropped_busy = 1'b0;
    while (ndone < 3 && waited < 300) begin
      @(negedge clk);
      waited++;
      if (!busy) dropped_busy = 1'b1;
      if (adc_valid && !adc_rst) nconv++;
      if (done) begin
        ndone++;
        rd_ch = 2'd0;
        #1;
        tests++; if (rd_val !== 16'h0200 + base + 16'(ndone - 1)) begin
          fails++; $display("FAIL cont_value%0d got %h want %h", ndone, rd_val, 16'h0200 + base + 16'(ndone - 1));
        end
        tests++; if (nconv != ndone) begin fails++; $display("FAIL cont_done_rate got conv=%0d done=%0d want equal", nconv, ndone); end
      end
    end
    tests++; if (ndone != 3 || dropped_busy !== 1'b0) begin fails++; $display("FAIL cont_run got done=%0d busydrop=%b want 3 0", ndone, dropped_busy); end
    waited = 0;
    while (!(adc_valid && !adc_rst) && waited < 50) begin @(negedge clk); waited++; end
    continuous = 1'b0;
    late_done = 0; waited = 0;
    while (busy && waited < 100) begin @(negedge clk); waited++; if (done) late_done++; end
    repeat (10) begin @(negedge clk); if (done) late_done++; end
    tests++; if (late_done != 1 || busy !== 1'b0) begin fails++; $display("FAIL cont_drop got done=%0d busy=%b want 1 0", late_done, busy); end
    mode_inc = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int waited;
    mode_inc = 1'b0;
    pulse_start(4'b1000, 8'd2, 5'd9);
    waited = 0;
    while (adc_rst && waited < 30) begin @(negedge clk); waited++; end
    tests++; if (adc_rst !== 1'b0 || adc_sel !== 2'd3) begin fails++; $display("FAIL mid_reach_conv got rst=%b sel=%0d want 0 3", adc_rst, adc_sel); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (adc_rst !== 1'b1) begin fails++; $display("FAIL mid_adc_rst got %b want 1", adc_rst); end
    tests++; if (busy !== 1'b0 || done !== 1'b0 || fresh !== 4'b0000) begin fails++; $display("FAIL mid_flags got busy=%b done=%b fresh=%b want 0 0 0000", busy, done, fresh); end
    tests++; if (adc_sel !== 2'd0 || adc_divider !== 5'd0) begin fails++; $display("FAIL mid_outputs got sel=%0d div=%0d want 0 0", adc_sel, adc_divider); end
    rd_ch = 2'd3;
    #1;
    tests++; if (rd_val !== 16'h0000) begin fails++; $display("FAIL mid_result got %h want 0000", rd_val); end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(4'b0100, 8'd0, 5'd2);
    run_until_done(100, ok);
    rd_ch = 2'd2;
    #1;
    tests++; if (ok !== 1'b1 || rd_val !== 16'h0102 || fresh !== 4'b0100) begin
      fails++; $display("FAIL mid_recover got ok=%b val=%h fresh=%b want 1 0102 0100", ok, rd_val, fresh);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; ch_mask = 4'b0000;
    divider_cfg = 5'd0; settle_cycles = 8'd0; rd_ch = 2'd0; rd_strobe = 1'b0;
    mode_inc = 1'b0; conv_count = 16'd0; prev_rst = 1'b1; stub_cnt = 2'd0; adc_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_sweep();
    test_timing();
    test_collision();
    test_mask_zero();
    test_start_busy();
    test_continuous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
